// File: rtl/if_prefetch_pkg.sv
// rtl/if_prefetch_pkg.sv - shared defaults and response classification for the fetch unit
//
// Purpose: default widths/reset PC used by if_prefetch, plus the decision of
// what to do with an incoming instruction-memory response.
// Ports: none (package).
package if_prefetch_pkg;

    localparam int          DEF_XLEN     = 64;
    localparam int          DEF_ILEN     = 32;
    localparam int          DEF_DEPTH    = 4;
    localparam logic [63:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_DROP = 2'd1,
        RESP_PUSH = 2'd2
    } resp_act_e;

    // A response belonging to a flushed stream, or arriving while a redirect
    // is being applied, never enters the queue.
    function automatic resp_act_e resp_action(input logic resp_valid,
                                              input logic redirect,
                                              input logic discard_pending);
        if (!resp_valid) begin
            return RESP_NONE;
        end
        if (redirect || discard_pending) begin
            return RESP_DROP;
        end
        return RESP_PUSH;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - register-based synchronous FIFO with flush
//
// Purpose: DEPTH-entry FIFO; head entry is read straight from storage flops.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_data     write one entry (accepted when not full, or when popping)
//   pop                 remove head entry (ignored when empty)
//   flush               drop all entries; wins over push and pop
//   full, empty, count  occupancy
//   head_data           oldest entry
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           head_data
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        // Push at full is legal when the head leaves in the same cycle.
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction fetch unit with prefetch queue and redirect flush
//
// Purpose: issues in-order fetches, buffers up to DEPTH {pc, inst} pairs and
// hands them to decode; a redirect flushes queued and in-flight instructions.
// Ports:
//   clk, rst                            clock, synchronous active-high reset
//   redirect_valid, redirect_pc         flush and restart fetch at redirect_pc
//   imem_req_valid/ready/addr           fetch request channel
//   imem_resp_valid/data                in-order responses, always accepted
//   inst_valid/ready, inst_data/pc      instruction to decode
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter int              ILEN     = DEF_ILEN,
    parameter int              DEPTH    = DEF_DEPTH,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int QW = XLEN + ILEN;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;

    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;
    logic [QW-1:0]   q_head;
    logic            q_push;
    logic            q_pop;
    logic [QW-1:0]   q_push_data;

    logic [CW:0]     in_use;
    logic            req_fire;
    resp_act_e       resp_act;
    logic [CW-1:0]   live_in_flight;
    logic [XLEN-1:0] resp_pc;

    // Slots already committed: queued entries plus live requests in flight.
    // Stale (discarded) requests never reach the queue, so they hold no slot.
    assign in_use         = {1'b0, q_count} + {1'b0, outstanding_q} - {1'b0, discard_q};
    assign imem_req_valid = !rst && (in_use < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_act = resp_action(imem_resp_valid, redirect_valid, discard_q != '0);

    // Live requests are the youngest ones and consecutive, so the oldest live
    // request sits that many words behind the fetch PC.
    assign live_in_flight = outstanding_q - discard_q;
    assign resp_pc        = fetch_pc_q - (XLEN'(live_in_flight) << 2);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_resp_valid);
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            // Everything still unanswered after this edge belongs to the old stream.
            discard_d  = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (resp_act == RESP_DROP) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    assign q_pop       = inst_valid && inst_ready;
    assign q_push      = (resp_act == RESP_PUSH) && (!q_full || q_pop);
    assign q_push_data = {resp_pc, imem_resp_data};

    sync_fifo #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (q_push_data),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .head_data (q_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    assign inst_valid = !q_empty;
    assign inst_pc    = q_head[QW-1:ILEN];
    assign inst_data  = q_head[ILEN-1:0];

endmodule
